edge_change_delay: RTL and testbench

EDGE_CHANGE_DELAY -- requirements
Module: edge_change_delay

---
 rtl/edge_change_delay.sv | 104 ++++++++++
 tb/tb_edge_change_delay.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/edge_change_delay.sv
// -----------------------------------------------------------------------------
// edge_change_delay
//
// Three independent sub-functions that share one clock enable:
//   * edge detect   : flags rising, falling and either edges of ed_i relative
//                     to the last enabled sample of ed_i.
//   * change detect : flags any bit difference between cd_i and the last
//                     enabled sample of cd_i.
//   * delay line    : DLY_DEP-stage shift register on dly_i (combinational
//                     bypass when DLY_DEP is 0).
// Flags are combinational from the current inputs, so they carry no added
// latency; only the sampled history is registered.
//
// Ports
//   clk    in   1        rising-edge clock
//   rst    in   1        asynchronous active-low reset (clears all state)
//   ce     in   1        clock enable; all state holds while low
//   ed_i   in   1        edge-detect input
//   ed_pe  out  1        ed_i high, previous sample low
//   ed_ne  out  1        ed_i low, previous sample high
//   ed_ee  out  1        ed_i differs from previous sample
//   cd_i   in   CD_WID   change-detect input
//   cd_o   out  1        cd_i differs from previous sample
//   dly_i  in   DLY_WID  delay-line input
//   dly_o  out  DLY_WID  dly_i delayed by DLY_DEP enabled edges
// -----------------------------------------------------------------------------
module edge_change_delay #(
    parameter int CD_WID  = 16,
    parameter int DLY_WID = 5,
    parameter int DLY_DEP = 3    // legal range 0..16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               ed_i,
    output logic               ed_pe,
    output logic               ed_ne,
    output logic               ed_ee,
    input  logic [CD_WID-1:0]  cd_i,
    output logic               cd_o,
    input  logic [DLY_WID-1:0] dly_i,
    output logic [DLY_WID-1:0] dly_o
);

    logic              ed_d;
    logic              ed_q;
    logic [CD_WID-1:0] cd_d;
    logic [CD_WID-1:0] cd_q;

    always_comb begin
        ed_d = ce ? ed_i : ed_q;
        cd_d = ce ? cd_i : cd_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ed_q <= 1'b0;
            cd_q <= '0;
        end else begin
            ed_q <= ed_d;
            cd_q <= cd_d;
        end
    end

    // Flags compare the live input against the held sample, so a held ce=0
    // keeps a flag asserted for as long as the input differs.
    assign ed_pe = ed_i & ~ed_q;
    assign ed_ne = ed_q & ~ed_i;
    assign ed_ee = ed_i ^ ed_q;
    assign cd_o  = (cd_i != cd_q);

    generate
        if (DLY_DEP == 0) begin : g_bypass
            assign dly_o = dly_i;
        end else begin : g_line
            logic [DLY_WID-1:0] dly_d [DLY_DEP];
            logic [DLY_WID-1:0] dly_q [DLY_DEP];

            always_comb begin
                dly_d[0] = ce ? dly_i : dly_q[0];
                for (int k = 1; k < DLY_DEP; k++) begin
                    dly_d[k] = ce ? dly_q[k-1] : dly_q[k];
                end
            end

            // Stage data is cleared on reset so that in-flight samples are
            // discarded and the line refills with zeros.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < DLY_DEP; k++) begin
                        dly_q[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < DLY_DEP; k++) begin
                        dly_q[k] <= dly_d[k];
                    end
                end
            end

            assign dly_o = dly_q[DLY_DEP-1];
        end
    endgenerate

endmodule

// File: tb/tb_edge_change_delay.sv
module tb_edge_change_delay;

    localparam int CD_WID  = 16;
    localparam int DLY_WID = 5;
    localparam int DLY_DEP = 3;

    logic               clk;
    logic               rst;
    logic               ce;
    logic               ed_i;
    logic [CD_WID-1:0]  cd_i;
    logic [DLY_WID-1:0] dly_i;

    logic               ed_pe, ed_ne, ed_ee, cd_o;
    logic [DLY_WID-1:0] dly_o;
    logic               ed_pe0, ed_ne0, ed_ee0, cd_o0;
    logic [DLY_WID-1:0] dly_o0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: last enabled samples and a queue of the values the
    // delay line currently holds (oldest first).
    logic               m_ed;
    logic [CD_WID-1:0]  m_cd;
    logic [DLY_WID-1:0] m_q [$];

    edge_change_delay #(.CD_WID(CD_WID), .DLY_WID(DLY_WID), .DLY_DEP(DLY_DEP)) u_dut (
        .clk(clk), .rst(rst), .ce(ce),
        .ed_i(ed_i), .ed_pe(ed_pe), .ed_ne(ed_ne), .ed_ee(ed_ee),
        .cd_i(cd_i), .cd_o(cd_o),
        .dly_i(dly_i), .dly_o(dly_o)
    );

    edge_change_delay #(.CD_WID(CD_WID), .DLY_WID(DLY_WID), .DLY_DEP(0)) u_dut0 (
        .clk(clk), .rst(rst), .ce(ce),
        .ed_i(ed_i), .ed_pe(ed_pe0), .ed_ne(ed_ne0), .ed_ee(ed_ee0),
        .cd_i(cd_i), .cd_o(cd_o0),
        .dly_i(dly_i), .dly_o(dly_o0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ed = 1'b0;
        m_cd = '0;
        m_q.delete();
        for (int k = 0; k < DLY_DEP; k++) m_q.push_back('0);
    endtask

    task automatic check_outputs();
        logic e_pe, e_ne, e_ee, e_cd;
        e_pe = (ed_i == 1'b1) && (m_ed == 1'b0);
        e_ne = (ed_i == 1'b0) && (m_ed == 1'b1);
        e_ee = (ed_i != m_ed);
        e_cd = (cd_i != m_cd);
        check("ed_pe", 32'(ed_pe), 32'(e_pe));
        check("ed_ne", 32'(ed_ne), 32'(e_ne));
        check("ed_ee", 32'(ed_ee), 32'(e_ee));
        check("pe_ne_excl", 32'(ed_pe & ed_ne), 32'd0);
        check("cd_o", 32'(cd_o), 32'(e_cd));
        check("dly_o", 32'(dly_o), 32'(m_q[0]));
        check("ed_pe0", 32'(ed_pe0), 32'(e_pe));
        check("ed_ne0", 32'(ed_ne0), 32'(e_ne));
        check("ed_ee0", 32'(ed_ee0), 32'(e_ee));
        check("cd_o0", 32'(cd_o0), 32'(e_cd));
        check("dly_o0", 32'(dly_o0), 32'(dly_i));
    endtask

    // Apply inputs just after an edge, check mid-cycle, then advance the
    // model on the next rising edge.
    task automatic step(input logic e, input logic ei,
                        input logic [CD_WID-1:0] ci, input logic [DLY_WID-1:0] di);
        ce    = e;
        ed_i  = ei;
        cd_i  = ci;
        dly_i = di;
        #2;
        check_outputs();
        @(posedge clk);
        if (ce) begin
            m_ed = ed_i;
            m_cd = cd_i;
            m_q.push_back(dly_i);
            void'(m_q.pop_front());
        end
        #1;
    endtask

    // Reset pulse between clock edges; outputs must clear before any edge.
    task automatic reset_pulse();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_dly_o", 32'(dly_o), 32'd0);
        check_outputs();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        ce    = 1'b0;
        ed_i  = 1'b1;
        cd_i  = 16'h00a5;
        dly_i = 5'd7;
        model_reset();
        #3;
        check("rst_ed_pe", 32'(ed_pe), 32'd1);
        check("rst_ed_ne", 32'(ed_ne), 32'd0);
        check("rst_cd_o", 32'(cd_o), 32'd1);
        check("rst_dly_o", 32'(dly_o), 32'd0);
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Rising edge then held high.
        step(1'b1, 1'b0, 16'h0000, 5'd0);
        step(1'b1, 1'b1, 16'h0000, 5'd0);
        check("pe_cleared", 32'(ed_pe), 32'd0);
        check("ee_cleared", 32'(ed_ee), 32'd0);
        step(1'b1, 1'b1, 16'h0000, 5'd0);
        // Falling edge, then one-cycle pulse.
        step(1'b1, 1'b0, 16'h0000, 5'd0);
        step(1'b1, 1'b1, 16'h0000, 5'd0);
        step(1'b1, 1'b0, 16'h0000, 5'd0);
        check("ne_after_pulse_clr", 32'(ed_ne), 32'd0);
        // ed_i high with ce low keeps ed_pe asserted.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'h0000, 5'd0);
            check("pe_hold_ce0", 32'(ed_pe), 32'd1);
        end
        step(1'b1, 1'b1, 16'h0000, 5'd0);

        // Change detect: 0x1234 held, then 0x1235 held.
        step(1'b1, 1'b1, 16'h1234, 5'd0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 16'h1234, 5'd0);
        step(1'b1, 1'b1, 16'h1235, 5'd0);
        check("cd_cleared", 32'(cd_o), 32'd0);
        step(1'b1, 1'b1, 16'h1235, 5'd0);
        step(1'b0, 1'b1, 16'h8000, 5'd0);
        check("cd_hold_ce0", 32'(cd_o), 32'd1);
        step(1'b0, 1'b1, 16'h8000, 5'd0);

        // Delay line 1..5 with a ce=0 bubble after the third value.
        reset_pulse();
        step(1'b1, 1'b0, 16'h0, 5'd1);
        step(1'b1, 1'b0, 16'h0, 5'd2);
        step(1'b1, 1'b0, 16'h0, 5'd3);
        check("dly_first", 32'(dly_o), 32'd1);
        step(1'b0, 1'b0, 16'h0, 5'd31);
        check("dly_bubble", 32'(dly_o), 32'd1);
        step(1'b1, 1'b0, 16'h0, 5'd4);
        check("dly_second", 32'(dly_o), 32'd2);
        step(1'b1, 1'b0, 16'h0, 5'd5);
        check("dly_third", 32'(dly_o), 32'd3);
        step(1'b1, 1'b0, 16'h0, 5'd0);
        step(1'b1, 1'b0, 16'h0, 5'd0);
        check("dly_fifth", 32'(dly_o), 32'd5);

        // Async reset with nonzero data in flight and cd_i equal to cd_q.
        step(1'b1, 1'b1, 16'hbeef, 5'd9);
        step(1'b1, 1'b1, 16'hbeef, 5'd10);
        check("cd_before_rst", 32'(cd_o), 32'd0);
        reset_pulse();
        check("cd_after_rst", 32'(cd_o), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 5'(i + 20));

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            logic [CD_WID-1:0] c;
            c = ($urandom_range(0, 2) == 0) ? 16'($urandom) : m_cd;
            if ($urandom_range(0, 3) == 0) c = 16'(c ^ (16'h1 << $urandom_range(0, 15)));
            if ($urandom_range(0, 60) == 0) reset_pulse();
            step(($urandom_range(0, 3) != 0), 1'($urandom), c, 5'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
